// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and sizing for the stochastic computing blocks
package sc_pkg;

  // Default window exponent: N = 2^SC_LOG_LEN bits per window
  localparam int SC_LOG_LEN = 6;

  // Accumulation state shared by the stochastic decoders
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } sc_state_e;

  // Result width: a count of 0..N needs LOG_LEN+1 bits, and the signed
  // bipolar form -N..+N needs one more
  function automatic int sc_res_width(input int log_len);
    return log_len + 2;
  endfunction

endpackage

// File: rtl/sc_dec_outreg.sv
// rtl/sc_dec_outreg.sv - valid/ready result holding register with overrun flag
module sc_dec_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] res,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic         ovf,
  input  logic         ovf_clr
);

  logic accept_load;
  logic drop;

  // A new result fits when the register is empty or being drained this cycle
  assign accept_load = load_vld && (!res_vld || res_rdy);
  assign drop        = load_vld && !accept_load;

  // Hold the result until the consumer takes it; a reload on the consuming
  // edge keeps res_vld high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res     <= '0;
      res_vld <= 1'b0;
    end else if (accept_load) begin
      res     <= load_data;
      res_vld <= 1'b1;
    end else if (res_rdy) begin
      res_vld <= 1'b0;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// rtl/sc_bitstream_decoder.sv - stochastic-to-binary window counter; SC_DECODER_BIPOLAR_EN selects signed output
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter  int LOG_LEN = SC_LOG_LEN,
  localparam int RW      = sc_res_width(LOG_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cont,
  input  logic          stop,
  input  logic          bit_in,
  input  logic          bit_vld,
  output logic [RW-1:0] res,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic          busy,
  output logic          ovf,
  input  logic          ovf_clr
);

  sc_state_e          state, state_nxt;
  logic [LOG_LEN-1:0] bit_cnt;
  logic [LOG_LEN:0]   ones_cnt;
  logic               cont_q;

  logic               acc_bit;
  logic               win_end;
  logic [LOG_LEN:0]   final_count;
  logic [RW-1:0]      res_word;

  // A bit counts only in ACC and only when no start/stop overrides the cycle
  assign acc_bit     = (state == ACC) && !start && !stop && bit_vld;
  assign win_end     = acc_bit && (&bit_cnt);
  assign final_count = ones_cnt + {{LOG_LEN{1'b0}}, bit_in};

`ifdef SC_DECODER_BIPOLAR_EN
  localparam logic [RW-1:0] N_WORD = RW'(1) << LOG_LEN;
  assign res_word = {final_count, 1'b0} - N_WORD;
`else
  assign res_word = {1'b0, final_count};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and busy; start beats stop, window end leaves unless continuous
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACC;
      end
      ACC: begin
        busy = 1'b1;
        if (start) begin
          state_nxt = ACC;
        end else if (stop) begin
          state_nxt = IDLE;
        end else if (win_end && !cont_q) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters; restart on the window-end edge so no bit is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
      cont_q   <= 1'b0;
    end else if (start) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
      cont_q   <= cont;
    end else if ((state == ACC) && stop) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (acc_bit) begin
      if (win_end) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end else begin
        bit_cnt  <= bit_cnt + 1'b1;
        ones_cnt <= final_count;
      end
    end
  end

  sc_dec_outreg #(
    .W (RW)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_vld  (win_end),
    .load_data (res_word),
    .res       (res),
    .res_vld   (res_vld),
    .res_rdy   (res_rdy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// tb/tb_sc_bitstream_decoder.sv - model-checked bench for the stochastic decoder
module tb_sc_bitstream_decoder;

  localparam int N  = 64;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          stop = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_vld = 1'b0;
  logic [RW-1:0] res;
  logic          res_vld;
  logic          res_rdy = 1'b0;
  logic          busy;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  sc_bitstream_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cont    (cont),
    .stop    (stop),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .res     (res),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .busy    (busy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] map_count(input int c);
`ifdef SC_DECODER_BIPOLAR_EN
    return RW'(2 * c - N);
`else
    return RW'(c);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: window membership tracked as a running tally of accepted bits
  bit            m_active, m_cont;
  int            m_seen, m_ones;
  bit            e_vld, e_ovf;
  logic [RW-1:0] e_res;
  bit            fin, consumed;
  int            cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_cont = 0; m_seen = 0; m_ones = 0;
      e_vld = 0; e_ovf = 0; e_res = '0;
    end else begin
      fin = 0; cnt = 0;
      consumed = e_vld && res_rdy;
      if (start) begin
        m_active = 1; m_cont = cont; m_seen = 0; m_ones = 0;
      end else if (m_active) begin
        if (stop) begin
          m_active = 0;
        end else if (bit_vld) begin
          m_seen++;
          m_ones += int'(bit_in);
          if (m_seen == N) begin
            fin = 1; cnt = m_ones; m_seen = 0; m_ones = 0;
            if (!m_cont) m_active = 0;
          end
        end
      end
      if (fin && (!e_vld || consumed)) begin
        e_vld = 1; e_res = map_count(cnt);
        if (ovf_clr) e_ovf = 0;
      end else begin
        if (consumed) e_vld = 0;
        if (fin) e_ovf = 1;
        else if (ovf_clr) e_ovf = 0;
      end
    end
  end

  // Every-cycle comparison against the model, half a cycle after the edge
  always @(negedge clk) begin
    chk("busy", busy, m_active);
    chk("res_vld", res_vld, e_vld);
    chk("res", res, e_res);
    chk("ovf", ovf, e_ovf);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; cont = 0; bit_vld = 0; bit_in = 0; ovf_clr = 0;
  endtask

  initial begin
    tick(3);
    chk("reset_res", res, 0);
    chk("reset_vld", res_vld, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ovf", ovf, 0);
    rst_n = 1;
    tick(2);

    // Single-shot all ones
    res_rdy = 1; start = 1; cont = 0; bit_vld = 1; bit_in = 1;
    tick(1);
    chk("ss_busy", busy, 1);
    start = 0;
    tick(N - 1);
    chk("ss_not_yet", res_vld, 0);
    tick(1);
    chk("ss_res", res, map_count(64));
    chk("ss_vld", res_vld, 1);
    chk("ss_busy_drop", busy, 0);
    idle_inputs();
    tick(1);
    chk("ss_vld_one_cycle", res_vld, 0);

    // Alternating bits, every third cycle invalid
    res_rdy = 0; start = 1; cont = 0;
    tick(1);
    start = 0;
    for (int i = 0, a = 0; i < 96; i++) begin
      bit_vld = (i % 3 != 2);
      bit_in  = bit_vld ? ((a % 2) == 0) : 1'b1;
      if (bit_vld) a++;
      tick(1);
    end
    chk("alt_res", res, map_count(32));
    chk("alt_vld", res_vld, 1);
    idle_inputs();
    res_rdy = 1; tick(1); res_rdy = 0;

    // Continuous with back-pressure, overflow, recovery
    start = 1; cont = 1; bit_vld = 1; bit_in = 1;
    tick(1);
    start = 0;
    tick(N);
    chk("cont_first", res, map_count(64));
    chk("cont_first_vld", res_vld, 1);
    chk("cont_no_ovf", ovf, 0);
    tick(N);
    chk("cont_ovf", ovf, 1);
    chk("cont_held", res, map_count(64));
    bit_vld = 0; res_rdy = 1; ovf_clr = 1;
    tick(1);
    ovf_clr = 0; bit_vld = 1;
    chk("cont_cleared", ovf, 0);
    chk("cont_drained", res_vld, 0);
    tick(N);
    chk("cont_again", res_vld, 1);
    chk("cont_again_ovf", ovf, 0);

    // Window end coinciding with consumption: second window all zeros
    res_rdy = 0; bit_in = 0;
    tick(N - 1);
    chk("coin_pre", res, map_count(64));
    res_rdy = 1;
    tick(1);
    chk("coin_vld", res_vld, 1);
    chk("coin_res", res, map_count(0));
    chk("coin_ovf", ovf, 0);
    idle_inputs(); stop = 1;
    tick(1);
    stop = 0;
    tick(1);
    res_rdy = 0;

    // Restart after 40 ones; only the following window counts
    start = 1; bit_vld = 1; bit_in = 1;
    tick(1);
    start = 0;
    tick(40);
    start = 1;
    tick(1);
    start = 0;
    for (int j = 0; j < N; j++) begin
      bit_in = (j < 20);
      tick(1);
    end
    chk("restart_res", res, map_count(20));
    chk("restart_vld", res_vld, 1);

    // Stop mid-window
    start = 1; bit_in = 1;
    tick(1);
    start = 0;
    tick(30);
    stop = 1;
    tick(1);
    stop = 0;
    chk("stop_busy", busy, 0);
    tick(50);
    chk("stop_res_kept", res, map_count(20));

    // Reset mid-window
    start = 1;
    tick(1);
    start = 0;
    tick(30);
    rst_n = 0;
    #1;
    chk("rst_res", res, 0);
    chk("rst_vld", res_vld, 0);
    chk("rst_busy", busy, 0);
    idle_inputs();
    tick(2);
    rst_n = 1;
    tick(1);

`ifdef SC_DECODER_BIPOLAR_EN
    res_rdy = 1; start = 1; bit_vld = 1; bit_in = 0;
    tick(1);
    start = 0;
    tick(N);
    chk("bip_zero", res, 8'hC0);
    start = 1;
    tick(1);
    start = 0;
    for (int j = 0; j < N; j++) begin
      bit_in = (j < 48);
      tick(1);
    end
    chk("bip_48", res, 8'd32);
    idle_inputs();
    tick(2);
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      start   = ($urandom_range(0, 149) == 0);
      cont    = $urandom_range(0, 1);
      stop    = ($urandom_range(0, 199) == 0);
      bit_vld = ($urandom_range(0, 9) < 8);
      bit_in  = ($urandom_range(0, 3) != 0);
      res_rdy = ($urandom_range(0, 9) < 3);
      ovf_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 0;
        tick(1);
        rst_n = 1;
      end
      tick(1);
    end

    idle_inputs();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
